// File: rtl/kernel_run_ctrl_pkg.sv
// Shared types and helpers for the kernel run sequencer.
package kernel_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_HALT  = 3'd4
  } run_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/kernel_run_ctrl_sync2.sv
// Two-flop level synchroniser for quasi-static VIO probes.
module ctrl_sync2 (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb sync_d = {sync_q[0], d};

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule

// File: rtl/kernel_run_ctrl.sv
// Run sequencer for an ap_ctrl_hs kernel: repeated runs, dataset stepping,
// per-run latency measurement and hang detection.
module kernel_run_ctrl
  import kernel_run_ctrl_pkg::*;
#(
  parameter int DATASET_NUM        = 8,
  parameter int DATASET_UPDATE_INV = 1,
  parameter int NUM_RUNS           = 0,
  parameter int GAP_CYCLES         = 16,
  parameter int TIMEOUT_CYCLES     = 2**24,
  parameter int CNT_WIDTH          = 32,
  localparam int SEL_W             = (DATASET_NUM > 1) ? $clog2(DATASET_NUM) : 1
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 run_en,
  output logic                 ap_start,
  input  logic                 ap_ready,
  input  logic                 ap_done,
  output logic [SEL_W-1:0]     dataset_sel,
  output logic                 dataset_adv,
  output logic [CNT_WIDTH-1:0] run_cnt,
  output logic [CNT_WIDTH-1:0] last_latency,
  output logic                 busy,
  output logic                 done_all,
  output logic                 timeout_err
);

  localparam int TW = $clog2(max2(TIMEOUT_CYCLES, GAP_CYCLES) + 1);
  localparam int UW = $clog2(DATASET_UPDATE_INV + 1);
  localparam logic [TW-1:0]        TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]        GAP_LAST = TW'(GAP_CYCLES - 1);
  localparam logic [UW-1:0]        UPD_LAST = UW'(DATASET_UPDATE_INV - 1);
  localparam logic [SEL_W-1:0]     SEL_LAST = SEL_W'(DATASET_NUM - 1);
  localparam logic [CNT_WIDTH-1:0] RUNS_LIM = CNT_WIDTH'(NUM_RUNS);

  logic en_s;

  ctrl_sync2 u_sync_run_en (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .d      (run_en),
    .q      (en_s)
  );

  run_state_e           state_q, state_d;
  logic [TW-1:0]        cnt_q, cnt_d;          // gap length in GAP, hang timer in START/WAIT
  logic [CNT_WIDTH-1:0] lat_q, lat_d;
  logic [CNT_WIDTH-1:0] last_lat_q, last_lat_d;
  logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
  logic [UW-1:0]        upd_q, upd_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 adv_q, adv_d;
  logic                 done_all_q, done_all_d;
  logic                 tmo_err_q, tmo_err_d;

  logic                 done_acc;
  logic [CNT_WIDTH-1:0] lat_inc;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    last_lat_d = last_lat_q;
    run_cnt_d  = run_cnt_q;
    upd_d      = upd_q;
    sel_d      = sel_q;
    adv_d      = 1'b0;
    done_all_d = done_all_q;
    tmo_err_d  = tmo_err_q;
    done_acc   = 1'b0;
    lat_inc    = (&lat_q) ? lat_q : lat_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (en_s) begin
          state_d = ST_START;
          cnt_d   = '0;
          lat_d   = '0;
        end
      end
      ST_START, ST_WAIT: begin
        lat_d = lat_inc;
        cnt_d = cnt_q + 1'b1;
        // A done on the last allowed cycle still counts as a good run.
        if (ap_done) begin
          done_acc = 1'b1;
          state_d  = ST_GAP;
          cnt_d    = '0;
        end else if (cnt_q == TMO_LAST) begin
          tmo_err_d = 1'b1;
          state_d   = ST_HALT;
        end else if (state_q == ST_START && ap_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (NUM_RUNS != 0 && run_cnt_q == RUNS_LIM) begin
            state_d    = ST_HALT;
            done_all_d = 1'b1;
          end else if (en_s) begin
            state_d = ST_START;
            lat_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HALT: begin
        if (!en_s) begin
          state_d    = ST_IDLE;
          done_all_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (done_acc) begin
      last_lat_d = lat_inc;
      run_cnt_d  = (&run_cnt_q) ? run_cnt_q : run_cnt_q + 1'b1;
      // Index and pulse move together so banks see a consistent select.
      if (upd_q == UPD_LAST) begin
        upd_d = '0;
        adv_d = 1'b1;
        sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
      end else begin
        upd_d = upd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      lat_q      <= '0;
      last_lat_q <= '0;
      run_cnt_q  <= '0;
      upd_q      <= '0;
      sel_q      <= '0;
      adv_q      <= 1'b0;
      done_all_q <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      last_lat_q <= last_lat_d;
      run_cnt_q  <= run_cnt_d;
      upd_q      <= upd_d;
      sel_q      <= sel_d;
      adv_q      <= adv_d;
      done_all_q <= done_all_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign ap_start     = (state_q == ST_START);
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign dataset_sel  = sel_q;
  assign dataset_adv  = adv_q;
  assign run_cnt      = run_cnt_q;
  assign last_latency = last_lat_q;
  assign done_all     = done_all_q;
  assign timeout_err  = tmo_err_q;

endmodule
